// File: rtl/csa_mult_seq.sv
// ---------------------------------------------------------------------------
// csa_mult_seq
//
// Purpose:
//   Sequential 16x16 unsigned multiplier. A single 16-bit carry-select adder
//   (csa_16bit, defined below) is reused across 16 shift-add iterations.
//   Operands arrive over one valid/ready handshake; the 32-bit product
//   leaves over a second valid/ready handshake.
//
// Ports:
//   clk        in   1   clock, rising edge
//   rst        in   1   asynchronous, active-high reset
//   in_valid   in   1   operand pair present
//   in_ready   out  1   block can accept operands (IDLE and rst low)
//   a          in  16   multiplicand, sampled on accept
//   b          in  16   multiplier, sampled on accept
//   out_valid  out  1   product available (DONE)
//   out_ready  in   1   consumer takes product
//   product    out 32   unsigned a*b, qualified by out_valid
//   busy       out  1   high in RUN or DONE
//
// Handshake rule (both ports): a transfer happens on a rising clock edge
// where valid and ready are both high. Once raised, out_valid and product
// stay stable until that transfer. in_valid is ignored while in_ready is low.
//
// Configuration:
//   CSA_MULT_ZERO_SKIP_EN  when defined, an operand pair containing a zero
//                          finishes after a single adder pass instead of 16.
// ---------------------------------------------------------------------------

// ---------------------------------------------------------------------------
// csa_16bit
//
// Purpose:
//   16-bit carry-select adder built from four 4-bit groups. Each group
//   precomputes its result for both possible carry-ins and the incoming
//   group carry selects between them.
//
// Ports:
//   a, b   in  16  addends
//   cin    in   1  carry in
//   sum    out 16  a + b + cin, low 16 bits
//   cout   out  1  carry out of bit 15
// ---------------------------------------------------------------------------
module csa_16bit (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        cin,
    output logic [15:0] sum,
    output logic        cout
);

    // carry[g] is the carry into group g; carry[4] is the final carry out.
    logic [4:0] carry;

    assign carry[0] = cin;

    for (genvar g = 0; g < 4; g++) begin : g_group
        logic [4:0] res_c0;
        logic [4:0] res_c1;

        // Both candidate results are formed in parallel with the lower groups.
        assign res_c0 = {1'b0, a[4*g+3 -: 4]} + {1'b0, b[4*g+3 -: 4]};
        assign res_c1 = {1'b0, a[4*g+3 -: 4]} + {1'b0, b[4*g+3 -: 4]} + 5'd1;

        assign sum[4*g+3 -: 4] = carry[g] ? res_c1[3:0] : res_c0[3:0];
        assign carry[g+1]      = carry[g] ? res_c1[4]   : res_c0[4];
    end

    assign cout = carry[4];

endmodule

module csa_mult_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] product,
    output logic        busy
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]  state;
    logic [3:0]  count;
    logic [15:0] acc_hi;
    logic [15:0] mq;
    logic [15:0] mcand;
    logic [31:0] product_r;

    logic [15:0] adder_b;
    logic [15:0] add_sum;
    logic        add_cout;
    logic        accept;

    // The multiplicand is gated by the current multiplier bit; the adder is
    // always in the path, even when the partial product is zero.
    assign adder_b = mq[0] ? mcand : 16'h0000;

    csa_16bit u_adder (
        .a    (acc_hi),
        .b    (adder_b),
        .cin  (1'b0),
        .sum  (add_sum),
        .cout (add_cout)
    );

    // in_ready is forced low during reset so nothing is accepted while the
    // state register is being cleared.
    assign in_ready  = (state == IDLE) && !rst;
    assign accept    = in_valid && in_ready;
    assign out_valid = (state == DONE);
    assign busy      = (state == RUN) || (state == DONE);
    assign product   = product_r;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            count     <= 4'd0;
            acc_hi    <= 16'h0000;
            mq        <= 16'h0000;
            mcand     <= 16'h0000;
            product_r <= 32'h0000_0000;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        mcand  <= a;
                        mq     <= b;
                        acc_hi <= 16'h0000;
                        count  <= 4'd0;
                        state  <= RUN;
`ifdef CSA_MULT_ZERO_SKIP_EN
                        // A zero operand makes the product zero. Clearing mq
                        // and jumping to the last iteration lets one adder
                        // pass of 0+0 produce it, so DONE follows one edge
                        // after accept.
                        if ((a == 16'h0000) || (b == 16'h0000)) begin
                            mq    <= 16'h0000;
                            count <= 4'd15;
                        end
`endif
                    end
                end

                RUN: begin
                    // {acc_hi, mq} <= {cout, sum, mq[15:1]}: the full 17-bit
                    // adder result is kept, the used multiplier bit drops out.
                    acc_hi <= {add_cout, add_sum[15:1]};
                    mq     <= {add_sum[0], mq[15:1]};
                    count  <= count + 4'd1;
                    if (count == 4'd15) begin
                        state     <= DONE;
                        // Product register updates only on completion, so an
                        // aborted or in-flight operation never shows up here.
                        product_r <= {add_cout, add_sum, mq[15:1]};
                    end
                end

                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_csa_mult_seq.sv
// ---------------------------------------------------------------------------
// tb_csa_mult_seq
//
// Purpose:
//   Self-checking bench for csa_mult_seq. Expected products come from plain
//   a*b arithmetic; expected timing comes from the documented cycle counts.
//   Directed cases cover reset, carry into the upper half, zero operands,
//   back-pressure, ignored in_valid, reset abort, then 100 random
//   back-to-back operations checked through an expected-product queue.
// ---------------------------------------------------------------------------
module tb_csa_mult_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] product;
    logic        busy;

    int checks = 0;
    int errors = 0;

`ifdef CSA_MULT_ZERO_SKIP_EN
    localparam int ZERO_LAT = 1;
`else
    localparam int ZERO_LAT = 16;
`endif

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    csa_mult_seq dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .product   (product),
        .busy      (busy)
    );

    // ---------------- checker ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ---------------- driver ----------------
    // One operation: present operands, measure edges from accept until
    // out_valid, optionally hold out_ready low for 'hold' cycles while
    // poking in_valid, then complete the output handshake.
    task automatic run_op(input logic [15:0] op_a, input logic [15:0] op_b,
                          input int hold, input int exp_lat, input string tag);
        logic [31:0] exp_p;
        int lat;
        exp_p = 32'(op_a) * 32'(op_b);

        @(negedge clk);
        check({tag, "_in_ready_idle"}, {31'b0, in_ready}, 32'd1);
        a         = op_a;
        b         = op_b;
        in_valid  = 1'b1;
        out_ready = (hold == 0);
        @(posedge clk);                       // accept edge T
        #1;
        in_valid = 1'b0;
        a = 16'($urandom);                    // post-accept changes must not matter
        b = 16'($urandom);

        lat = 0;
        do begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            in_valid = 1'b0;
            if (!out_valid && lat == 5 && hold > 0) begin
                check({tag, "_run_in_ready"}, {31'b0, in_ready}, 32'd0);
                check({tag, "_run_busy"}, {31'b0, busy}, 32'd1);
                in_valid = 1'b1;              // must be ignored during RUN
            end
        end while (!out_valid && lat < 40);

        check({tag, "_latency"}, 32'(lat), 32'(exp_lat));
        check({tag, "_product"}, product, exp_p);
        check({tag, "_busy_done"}, {31'b0, busy}, 32'd1);

        for (int i = 0; i < hold; i++) begin
            check({tag, "_hold_in_ready"}, {31'b0, in_ready}, 32'd0);
            in_valid = 1'b1;                  // must be ignored during DONE
            a = 16'($urandom);
            b = 16'($urandom);
            @(posedge clk);
            @(negedge clk);
            check({tag, "_hold_valid"}, {31'b0, out_valid}, 32'd1);
            check({tag, "_hold_product"}, product, exp_p);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;

        // Handshake cycle: no same-cycle DONE-to-accept.
        check({tag, "_hs_in_ready"}, {31'b0, in_ready}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        check({tag, "_post_valid"}, {31'b0, out_valid}, 32'd0);
        check({tag, "_post_busy"}, {31'b0, busy}, 32'd0);
        check({tag, "_post_in_ready"}, {31'b0, in_ready}, 32'd1);
        check({tag, "_post_product"}, product, exp_p);
    endtask

    // ---------------- scoreboard ----------------
    logic [31:0] exp_q[$];

    initial begin
        int n_acc;
        int last_acc;
        int cyc;
        logic new_ops;

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = 16'h0000;
        b         = 16'h0000;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_product", product, 32'd0);
        check("rst_in_ready", {31'b0, in_ready}, 32'd0);
        rst = 1'b0;
        #1;
        check("rel_in_ready", {31'b0, in_ready}, 32'd1);

        // Directed operations
        run_op(16'h0003, 16'h0005, 0, 16, "small");
        run_op(16'hFFFF, 16'hFFFF, 0, 16, "max");
        run_op(16'h8000, 16'h0002, 0, 16, "carry");
        run_op(16'h1234, 16'h0000, 0, ZERO_LAT, "zero_b");
        run_op(16'h00FF, 16'h0101, 10, 16, "backpressure");

        // Reset abort in the middle of RUN
        @(negedge clk);
        a         = 16'hABCD;
        b         = 16'h1234;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (7) @(posedge clk);
        @(negedge clk);
        check("abort_busy_before", {31'b0, busy}, 32'd1);
        rst = 1'b1;
        #1;
        check("abort_out_valid", {31'b0, out_valid}, 32'd0);
        check("abort_busy", {31'b0, busy}, 32'd0);
        check("abort_product", product, 32'd0);
        check("abort_in_ready", {31'b0, in_ready}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("abort_rel_in_ready", {31'b0, in_ready}, 32'd1);
        run_op(16'h0007, 16'h0009, 0, 16, "after_abort");

        // 100 back-to-back random operations
        n_acc    = 0;
        last_acc = -1;
        cyc      = 0;
        new_ops  = 1'b0;
        @(negedge clk);
        a         = 16'($urandom);
        b         = 16'($urandom);
        in_valid  = 1'b1;
        out_ready = 1'b1;
        while ((n_acc < 100 || exp_q.size() > 0) && cyc < 2500) begin
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    check("b2b_spurious_valid", {31'b0, out_valid}, 32'd0);
                end else begin
                    check("b2b_product", product, exp_q.pop_front());
                end
            end
            if (new_ops) begin
                new_ops = 1'b0;
                a = 16'($urandom);
                b = 16'($urandom);
                if (n_acc >= 100) in_valid = 1'b0;
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(32'(a) * 32'(b));
                if (last_acc >= 0) check("b2b_spacing", 32'(cyc - last_acc), 32'd18);
                last_acc = cyc;
                n_acc++;
                new_ops = 1'b1;
            end
            @(posedge clk);
            @(negedge clk);
            cyc++;
        end
        in_valid = 1'b0;
        check("b2b_accepts", 32'(n_acc), 32'd100);
        check("b2b_drained", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
